// File: rtl/multi_port_regfile.sv
// ============================================================================
// multi_port_regfile
// ----------------------------------------------------------------------------
// Parametrised register file with NUM_RD read ports and NUM_WR write ports.
// Features:
//   - same-cycle write->read bypass (BYPASS=1)
//   - hard-wired zero entry at address 0 (ZERO_REG=1)
//   - optional registered read stage (RD_LATENCY=1)
//   - post-reset clear sequencer that zeroes every entry; oReady gates use
//
// Ports:
//   iClk       in   1                   clock, all logic on posedge
//   iRst_n     in   1                   synchronous active-low reset
//   iRdEn      in   NUM_RD              per-port read enable
//   iRdAddr    in   NUM_RD*ADDR_WIDTH   packed read addresses, port p at [p*AW +: AW]
//   oRdData    out  NUM_RD*DATA_WIDTH   packed read data, port p at [p*DW +: DW]
//   iWe        in   NUM_WR              per-port write enable
//   iWrAddr    in   NUM_WR*ADDR_WIDTH   packed write addresses
//   iWrData    in   NUM_WR*DATA_WIDTH   packed write data
//   oReady     out  1                   1 = clear complete, accesses honoured
//   oConflict  out  1                   pulse: previous cycle had >=2 writes to one address
// ============================================================================
module multi_port_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RD_LATENCY = 0
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    input  logic [NUM_RD-1:0]            iRdEn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] iRdAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] oRdData,
    input  logic [NUM_WR-1:0]            iWe,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] iWrAddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] iWrData,
    output logic                         oReady,
    output logic                         oConflict
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    localparam bit ZERO_EN   = (ZERO_REG != 32'sd0);
    localparam bit BYPASS_EN = (BYPASS != 32'sd0);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic                    ready_r;
    logic                    conflict_r;
    logic [DATA_WIDTH-1:0]   ram_r [DEPTH];

    logic [ADDR_WIDTH-1:0]   wr_addr_s [NUM_WR];
    logic [DATA_WIDTH-1:0]   wr_data_s [NUM_WR];
    logic [NUM_WR-1:0]       wr_act_s;
    logic [ADDR_WIDTH-1:0]   rd_addr_s [NUM_RD];
    logic [DATA_WIDTH-1:0]   rd_val_s  [NUM_RD];
    logic                    conflict_s;

    // Unpack the flat port vectors and qualify each write with run state and the zero entry.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_addr_s[w] = iWrAddr[w*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_s[w] = iWrData[w*DATA_WIDTH +: DATA_WIDTH];
            // A write to the hard-wired zero entry is dropped entirely, so it
            // neither updates memory, bypasses, nor counts toward a conflict.
            wr_act_s[w]  = iWe[w] && (state_r == ST_RUN) &&
                           !(ZERO_EN && (wr_addr_s[w] == ADDR_ZERO));
        end
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_s[p] = iRdAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Flag any pair of effective writes that target the same address this cycle.
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                conflict_s = conflict_s |
                             (wr_act_s[i] && wr_act_s[j] && (wr_addr_s[i] == wr_addr_s[j]));
            end
        end
    end

    // Per-port read value: stored word, overridden by bypass, overridden by the zero entry.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val_s[p] = ram_r[rd_addr_s[p]];
            // Ascending scan so the highest-index matching writer is the last to land.
            for (int w = 0; w < NUM_WR; w++) begin
                rd_val_s[p] = (BYPASS_EN && wr_act_s[w] && (wr_addr_s[w] == rd_addr_s[p])) ?
                              wr_data_s[w] : rd_val_s[p];
            end
            rd_val_s[p] = (ZERO_EN && (rd_addr_s[p] == ADDR_ZERO)) ? DATA_ZERO : rd_val_s[p];
        end
    end

    // Clear sequencer: walks every entry once after reset, then enables accesses.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_r    <= ST_INIT;
            clr_cnt_r  <= ADDR_ZERO;
            ready_r    <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    clr_cnt_r  <= clr_cnt_r + ADDR_ONE;
                    conflict_r <= 1'b0;
                    if (clr_cnt_r == ADDR_LAST) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_INIT;
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r    <= ST_RUN;
                    ready_r    <= 1'b1;
                    conflict_r <= conflict_s;
                end
                default: begin
                    state_r    <= ST_INIT;
                    clr_cnt_r  <= ADDR_ZERO;
                    ready_r    <= 1'b0;
                    conflict_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: cleared one entry per cycle during INIT, written by the ports during RUN.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            // Contents are left alone during reset; the clear sequence follows.
        end else if (state_r == ST_INIT) begin
            ram_r[clr_cnt_r] <= DATA_ZERO;
        end else begin
            // Later (higher-index) ports overwrite earlier ones on an address clash.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act_s[w]) begin
                    ram_r[wr_addr_s[w]] <= wr_data_s[w];
                end
            end
        end
    end

    assign oReady    = ready_r;
    assign oConflict = conflict_r;

    generate
        if (RD_LATENCY == 0) begin : g_rd_comb
            // Combinational read: zero when disabled or while the clear is running.
            always_comb begin
                for (int p = 0; p < NUM_RD; p++) begin
                    if ((state_r == ST_RUN) && iRdEn[p]) begin
                        oRdData[p*DATA_WIDTH +: DATA_WIDTH] = rd_val_s[p];
                    end else begin
                        oRdData[p*DATA_WIDTH +: DATA_WIDTH] = DATA_ZERO;
                    end
                end
            end
        end else begin : g_rd_reg
            logic [DATA_WIDTH-1:0] rd_data_r [NUM_RD];

            // Registered read stage: captures on enable, holds otherwise, zero during clear.
            always_ff @(posedge iClk) begin
                if (!iRst_n) begin
                    for (int p = 0; p < NUM_RD; p++) begin
                        rd_data_r[p] <= DATA_ZERO;
                    end
                end else if (state_r == ST_INIT) begin
                    for (int p = 0; p < NUM_RD; p++) begin
                        rd_data_r[p] <= DATA_ZERO;
                    end
                end else begin
                    for (int p = 0; p < NUM_RD; p++) begin
                        if (iRdEn[p]) begin
                            rd_data_r[p] <= rd_val_s[p];
                        end
                    end
                end
            end

            // Pack the read registers onto the flat output bus.
            always_comb begin
                for (int p = 0; p < NUM_RD; p++) begin
                    oRdData[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_r[p];
                end
            end
        end
    endgenerate

endmodule
